// File: rtl/blue_sequencer.sv
// blue_sequencer: fetch/decode/execute controller for the blue datapath.
// Holds PC, IR, operand registers RA/RB and the latched {Z,N,C} flags,
// fetches program words over a req/valid handshake and steers the datapath.
module blue_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  instr_addr,
  output logic        instr_req,
  input  logic [15:0] instr_data,
  input  logic        instr_valid,
  output logic [15:0] opCode,
  output logic [15:0] A_out,
  output logic [15:0] B_out,
  input  logic [15:0] A_res,
  input  logic [15:0] B_res,
  input  logic [2:0]  ZNC_in,
  output logic [2:0]  flags,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    IMM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] rb_q, rb_d;
  logic [2:0]  flags_q, flags_d;
  logic        branchTaken;

  // A branch is taken unconditionally for an empty mask, otherwise when any
  // masked bit is set in the latched flags (never the live datapath flags).
  assign branchTaken = (ir_q[12:10] == 3'b000) || ((ir_q[12:10] & flags_q) != 3'b000);

  // State and architectural registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      ra_q    <= 16'h0000;
      rb_q    <= 16'h0000;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and register-update logic; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = 8'h00;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        unique case (ir_q[15:14])
          2'b00: state_d = EXEC;
          2'b01: state_d = IMM;
          2'b10: begin
            if (branchTaken) begin
              pc_d = ir_q[7:0];
            end
            state_d = FETCH;
          end
          default: state_d = HALT;
        endcase
      end
      EXEC: begin
        ra_d    = A_res;
        if (ir_q[13]) begin
          rb_d = B_res;
        end
        flags_d = ZNC_in;
        state_d = FETCH;
      end
      IMM: begin
        if (instr_valid) begin
          pc_d = pc_q + 8'd1;
          if (ir_q[13]) begin
            rb_d = instr_data;
          end else begin
            ra_d = instr_data;
          end
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_addr = pc_q;
  assign instr_req  = (state_q == FETCH) || (state_q == IMM);
  assign opCode     = (state_q == EXEC) ? ir_q : 16'h0000;
  assign A_out      = ra_q;
  assign B_out      = rb_q;
  assign flags      = flags_q;
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_blue_sequencer.sv
// Scoreboard bench for blue_sequencer: directed programs, a behavioural
// program memory, and monitors that pop expected fetches/execs/halts.
module tb_blue_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  instr_addr;
   logic        instr_req;
   logic [15:0] instr_data;
   logic        instr_valid;
   logic [15:0] opCode;
   logic [15:0] A_out;
   logic [15:0] B_out;
   logic [15:0] A_res;
   logic [15:0] B_res;
   logic [2:0]  ZNC_in;
   logic [2:0]  flags;
   logic        busy;
   logic        halted;

   typedef struct packed {
      logic [15:0] op;
      logic [15:0] a;
      logic [15:0] b;
   } execRec_t;

   typedef struct packed {
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  fl;
      logic [7:0]  pc;
   } haltRec_t;

   logic [7:0]  expAddrQ[$];
   execRec_t    expExecQ[$];
   haltRec_t    expHaltQ[$];

   logic [15:0] mem [256];
   int          memWait = 1;
   bit          memStall = 1'b0;
   int          waitCnt = 0;
   int          errors = 0;
   int          checks = 0;
   logic        haltedPrev = 1'b0;

   blue_sequencer dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .instr_addr(instr_addr),
      .instr_req(instr_req),
      .instr_data(instr_data),
      .instr_valid(instr_valid),
      .opCode(opCode),
      .A_out(A_out),
      .B_out(B_out),
      .A_res(A_res),
      .B_res(B_res),
      .ZNC_in(ZNC_in),
      .flags(flags),
      .busy(busy),
      .halted(halted)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
   endtask

   task automatic waitHalted(input int maxCycles);
      int n;
      n = 0;
      while (!halted && n < maxCycles) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (!halted) begin
         checks++;
         errors++;
         $display("[TB] FAIL haltTimeout: got halted=%0b, expected halted=1 within %0d cycles", halted, maxCycles);
      end
      @(negedge clk);
      #3;
   endtask

   // Program memory: answers a request after memWait idle cycles, one word per handshake.
   initial begin
      instr_valid = 1'b0;
      instr_data  = 16'h0000;
      forever begin
         @(negedge clk);
         if (instr_valid) begin
            instr_valid = 1'b0;
            waitCnt     = 0;
         end else if (instr_req && !memStall) begin
            if (waitCnt >= memWait) begin
               instr_valid = 1'b1;
               instr_data  = mem[instr_addr];
            end else begin
               waitCnt++;
            end
         end else begin
            waitCnt = 0;
         end
      end
   end

   // Monitor: compares fetch addresses, EXEC cycles and halt entry against the queues.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n) begin
            if (instr_req && instr_valid) begin
               if (expAddrQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedFetch: got addr 0x%02h, expected no fetch", instr_addr);
               end else begin
                  checkOutput("fetchAddr", 16'(instr_addr), 16'(expAddrQ.pop_front()));
               end
            end
            if (opCode != 16'h0000) begin
               if (expExecQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedExec: got opCode 0x%04h, expected none", opCode);
               end else begin
                  execRec_t e;
                  e = expExecQ.pop_front();
                  checkOutput("execOpCode", opCode, e.op);
                  checkOutput("execAout", A_out, e.a);
                  checkOutput("execBout", B_out, e.b);
               end
            end
            if (halted && !haltedPrev) begin
               if (expHaltQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedHalt: got halted=1 at PC 0x%02h, expected none", instr_addr);
               end else begin
                  haltRec_t h;
                  h = expHaltQ.pop_front();
                  checkOutput("haltRA", A_out, h.ra);
                  checkOutput("haltRB", B_out, h.rb);
                  checkOutput("haltFlags", 16'(flags), 16'(h.fl));
                  checkOutput("haltPC", 16'(instr_addr), 16'(h.pc));
               end
            end
         end
         haltedPrev = halted;
      end
   end

   // Absolute watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int n;
      reset_n = 1'b1;
      start   = 1'b0;
      A_res   = 16'h0000;
      B_res   = 16'h0000;
      ZNC_in  = 3'b000;
      clearMem();
      #1;
      reset_n = 1'b0;
      #2;
      checkOutput("rstReq", 16'(instr_req), 16'h0);
      checkOutput("rstOpCode", opCode, 16'h0);
      checkOutput("rstBusy", 16'(busy), 16'h0);
      checkOutput("rstHalted", 16'(halted), 16'h0);
      checkOutput("rstAddr", 16'(instr_addr), 16'h0);
      checkOutput("rstFlags", 16'(flags), 16'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      checkOutput("idleBusy", 16'(busy), 16'h0);

      // Load-immediate into RA and RB, then halt.
      mem[0] = 16'h4000; mem[1] = 16'h0005; mem[2] = 16'h6000; mem[3] = 16'h0003; mem[4] = 16'hC000;
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01); expAddrQ.push_back(8'h02);
      expAddrQ.push_back(8'h03); expAddrQ.push_back(8'h04);
      expHaltQ.push_back('{ra: 16'h0005, rb: 16'h0003, fl: 3'b000, pc: 8'h05});
      applyStimulus();
      waitHalted(100);

      // ALU writes: RA only, then RA and RB; flags latched from ZNC_in.
      clearMem();
      mem[0] = 16'h0123; mem[1] = 16'h2456; mem[2] = 16'hC000;
      A_res = 16'h0000; B_res = 16'h7777; ZNC_in = 3'b100;
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01); expAddrQ.push_back(8'h02);
      expExecQ.push_back('{op: 16'h0123, a: 16'h0005, b: 16'h0003});
      expExecQ.push_back('{op: 16'h2456, a: 16'h0000, b: 16'h0003});
      expHaltQ.push_back('{ra: 16'h0000, rb: 16'h7777, fl: 3'b100, pc: 8'h03});
      applyStimulus();
      waitHalted(100);

      // Branches: taken on Z, not taken once flags become N, unconditional jump.
      clearMem();
      mem[0] = 16'h9010; mem[8'h10] = 16'h0001; mem[8'h11] = 16'h9010; mem[8'h12] = 16'h8020;
      A_res = 16'h1111; B_res = 16'h2222; ZNC_in = 3'b010;
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h10); expAddrQ.push_back(8'h11);
      expAddrQ.push_back(8'h12); expAddrQ.push_back(8'h20);
      expExecQ.push_back('{op: 16'h0001, a: 16'h0000, b: 16'h7777});
      expHaltQ.push_back('{ra: 16'h1111, rb: 16'h7777, fl: 3'b010, pc: 8'h21});
      applyStimulus();
      waitHalted(100);

      // Stalled fetch: request held at address 0, start ignored while busy.
      clearMem();
      memStall = 1'b1;
      expAddrQ.push_back(8'h00);
      expHaltQ.push_back('{ra: 16'h1111, rb: 16'h7777, fl: 3'b010, pc: 8'h01});
      applyStimulus();
      for (int i = 0; i < 7; i++) begin
         start = (i == 3);
         @(negedge clk);
         #3;
         checkOutput("stallReq", 16'(instr_req), 16'h1);
         checkOutput("stallAddr", 16'(instr_addr), 16'h0);
         checkOutput("stallBusy", 16'(busy), 16'h1);
      end
      start = 1'b0;
      memStall = 1'b0;
      waitHalted(100);

      // PC wrap: load-immediate at 0xFF fetches its operand from 0x00.
      clearMem();
      mem[0] = 16'h80FF; mem[8'hFF] = 16'h4000; mem[1] = 16'hC000;
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'hFF);
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01);
      expHaltQ.push_back('{ra: 16'h80FF, rb: 16'h7777, fl: 3'b010, pc: 8'h02});
      applyStimulus();
      waitHalted(100);

      // Reset during EXEC aborts the write; a fresh start resumes from 0.
      clearMem();
      mem[0] = 16'h0003;
      A_res = 16'hABCD; ZNC_in = 3'b001;
      expAddrQ.push_back(8'h00);
      expExecQ.push_back('{op: 16'h0003, a: 16'h80FF, b: 16'h7777});
      applyStimulus();
      n = 0;
      while (opCode != 16'h0003 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      checkOutput("reachExec", opCode, 16'h0003);
      reset_n = 1'b0;
      #1;
      checkOutput("midRstOpCode", opCode, 16'h0);
      checkOutput("midRstBusy", 16'(busy), 16'h0);
      checkOutput("midRstRA", A_out, 16'h0);
      checkOutput("midRstRB", B_out, 16'h0);
      checkOutput("midRstFlags", 16'(flags), 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #3;
         checkOutput("postRstIdleReq", 16'(instr_req), 16'h0);
         checkOutput("postRstIdleBusy", 16'(busy), 16'h0);
      end
      clearMem();
      expAddrQ.push_back(8'h00);
      expHaltQ.push_back('{ra: 16'h0000, rb: 16'h0000, fl: 3'b000, pc: 8'h01});
      applyStimulus();
      waitHalted(100);

      checkOutput("leftoverExpected", 16'(expAddrQ.size() + expExecQ.size() + expHaltQ.size()), 16'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/blue_sequencer.md
BLUE_SEQUENCER -- requirements
Module: blue_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The module SHALL have the following ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle run request
- instr_addr  output  8  program word address (PC)
- instr_req  output  1  fetch request
- instr_data  input  16  program word
- instr_valid  input  1  instr_data valid
- opCode  output  16  opcode to the blue datapath
- A_out  output  16  operand A to the datapath (register RA)
- B_out  output  16  operand B to the datapath (register RB)
- A_res  input  16  datapath A result
- B_res  input  16  datapath B result
- ZNC_in  input  3  datapath flags {Z,N,C}
- flags  output  3  latched {Z,N,C}
- busy  output  1  high in every state except IDLE and HALT
- halted  output  1  high in HALT

Function
REQ-003 The state machine SHALL have the states IDLE, FETCH, DECODE, EXEC, IMM, HALT.
REQ-004 IDLE: start=1 SHALL set PC=0 and go to FETCH; otherwise the state SHALL hold.
REQ-005 FETCH: instr_req SHALL be 1 and instr_addr=PC held stable; at the edge where instr_valid=1, IR<=instr_data, PC<=PC+1 (8-bit, 255 wraps to 0), go to DECODE; instr_valid=0 SHALL hold FETCH indefinitely.
REQ-006 instr_req SHALL be 0 outside FETCH and IMM; instr_valid outside those states SHALL be ignored.
REQ-007 DECODE SHALL branch on IR[15:14]:
- 00 ALU -> EXEC
- 01 load-immediate -> IMM
- 10 branch -> FETCH
- 11 halt -> HALT
REQ-008 EXEC SHALL last exactly one cycle; opCode=IR during EXEC and 16'h0000 in all other states.
REQ-009 At the end of EXEC: RA<=A_res, RB<=B_res if IR[13]=1 (else RB unchanged), flags<=ZNC_in, then go to FETCH.
REQ-010 IMM SHALL behave like FETCH (request at PC, wait for valid, PC<=PC+1), then load instr_data into RA if IR[13]=0, else into RB, then go to FETCH; flags SHALL be unchanged.
REQ-011 Branch in DECODE: mask=IR[12:10], target=IR[7:0].
- Taken when mask=3'b000, or (mask & flags)!=0.
- Taken: PC<=target. Not taken: PC unchanged (already incremented).
REQ-012 Branch resolution SHALL use the flags register value, not ZNC_in.
REQ-013 HALT: halted=1, busy=0; start=1 SHALL set PC=0 and go to FETCH, with RA, RB and flags retained.
REQ-014 start asserted in any state other than IDLE or HALT SHALL be ignored.
REQ-015 Latency: ALU instruction = fetch wait + 3 cycles (FETCH, DECODE, EXEC); load-immediate = 2 fetch handshakes + 1; branch = fetch + 2.
REQ-016 A_out and B_out SHALL be driven directly from RA and RB, so they are stable throughout EXEC.

Reset
REQ-017 reset_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, PC=0, IR=0, RA=0, RB=0, flags=0, instr_req=0, opCode=0, busy=0, halted=0.
REQ-018 Reset asserted mid-fetch or mid-EXEC SHALL abort the operation, with no register write; after release the block SHALL sit in IDLE until start.

Verification
REQ-019 Program {0x4000, 0x0005, 0x6000, 0x0003, 0xC000}, valid returned one cycle after each request, then start -> RA=5, RB=3, halted=1, flags=0, PC=5.
REQ-020 ALU word 0x0123 in EXEC with the model returning A_res=0x0000 and ZNC_in=3'b100 -> opCode=0x0123 for exactly one cycle, RA=0, flags=3'b100, RB unchanged.
REQ-021 flags=3'b100 and branch 0x9010 (mask Z, target 0x10) -> next instr_addr=0x10; with flags=3'b010 the same word -> next instr_addr=PC of branch+1.
REQ-022 instr_valid held low for 7 cycles in FETCH -> instr_req high and instr_addr constant throughout, no state advance, busy=1.
REQ-023 PC=0xFF fetching a non-branch word -> next instr_addr=0x00.
REQ-024 reset_n pulsed low during EXEC -> all outputs 0 asynchronously, RA not updated; a start pulse after release resumes from address 0.
